// File: rtl/huffman_bit_buffer.sv
// LSB-first bit accumulator feeding a PEEK_W-bit look-ahead window to the Huffman decoder.
// Optional feature macro HBUF_ERR_EN: enables the sticky protocol-error flag (err tied low otherwise).
module huffman_bit_buffer #(
   parameter int  BUF_W  = 16,
   parameter int  IN_W   = 4,
   parameter int  PEEK_W = 9,
   localparam int CNT_W  = $clog2(BUF_W + 1),
   localparam int ILEN_W = $clog2(IN_W + 1),
   localparam int CLEN_W = $clog2(PEEK_W + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [IN_W-1:0]   in_bits,
   input  logic [ILEN_W-1:0] in_len,
   input  logic              consume_en,
   input  logic [CLEN_W-1:0] consume_len,
   input  logic              flush,
   output logic [PEEK_W-1:0] peek_bits,
   output logic [CNT_W-1:0]  bit_count,
   output logic              err
);

   localparam logic [CNT_W-1:0]  READY_MAX = CNT_W'(BUF_W - IN_W);
   localparam logic [ILEN_W-1:0] IN_MAX    = ILEN_W'(IN_W);
   localparam logic [CLEN_W-1:0] PEEK_MAX  = CLEN_W'(PEEK_W);

   logic [BUF_W-1:0] bits_q, bits_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             accept;
   logic             take;
   logic [CNT_W-1:0] accLen;
   logic [CNT_W-1:0] tkLen;
   logic [CNT_W-1:0] keepLen;
   logic [BUF_W-1:0] maskedIn;

   assign s_ready = !flush && (count_q <= READY_MAX);
   assign accept  = s_valid && s_ready && (in_len != '0) && (in_len <= IN_MAX);
   assign take    = consume_en && (CNT_W'(consume_len) <= count_q) && (consume_len <= PEEK_MAX);

   // Consume shifts first; the masked chunk then lands directly above the surviving bits.
   always_comb begin
      maskedIn = '0;
      for (int i = 0; i < IN_W; i++) begin
         maskedIn[i] = accept && in_bits[i] && (i < int'(in_len));
      end
      accLen  = accept ? CNT_W'(in_len) : '0;
      tkLen   = take ? CNT_W'(consume_len) : '0;
      keepLen = count_q - tkLen;
      if (flush) begin
         bits_d  = '0;
         count_d = '0;
      end else begin
         bits_d  = (bits_q >> tkLen) | (maskedIn << keepLen);
         count_d = keepLen + accLen;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bits_q  <= '0;
         count_q <= '0;
      end else begin
         bits_q  <= bits_d;
         count_q <= count_d;
      end
   end

   assign peek_bits = bits_q[PEEK_W-1:0];
   assign bit_count = count_q;

`ifdef HBUF_ERR_EN
   logic err_q;
   logic protoErr;

   assign protoErr = !flush &&
                     ((consume_en && !take) || (s_valid && s_ready && (in_len > IN_MAX)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (protoErr) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Bits above the fill level must stay clear so the peek window reads zeros there.
   assert property (@(posedge clk) disable iff (!reset_n) ((bits_q >> count_q) == '0));
   assert property (@(posedge clk) disable iff (!reset_n) (count_q <= CNT_W'(BUF_W)));

endmodule
